inout_port_param: RTL
=====================

// Module: inout_port_param
// PURPOSE
//  Parametrised router in/out port, successor to the fixed 32-bit port. It accepts packets from an upstream
//  link and buffers them in a FIFO. It decodes the header destination into a one-hot crossbar configuration,
//  then forwards the flits downstream under credit flow control. It sits between a link and one crossbar
//  input of a router.
// PARAMETERS
//  FLIT_W     32  flit width in bits
//  BUF_DEPTH  4   input FIFO depth in flits; power of two, >=2
//  PORTS      4   crossbar outputs, which is the width of xbar_cfg_vector; power of two
//  PKT_FLITS  4   flits per packet, header included; >=2
//  DST_LSB    24  LSB of the destination field in the header; field width DST_W=$clog2(PORTS)
//  CREDITS    4   downstream buffer credits loaded at reset
//  WDOG_CYC   64  watchdog stall limit in cycles; used only when INOUT_PORT_WDOG_EN is defined
// PORTS
//  clk              in   1          single clock, all logic on its rising edge
//  rst              in   1          asynchronous, active-low reset
//  diff_pair_p_in   in   1          differential packet-start toggle, P leg
//  diff_pair_n_in   in   1          differential packet-start toggle, N leg
//  input_channel    in   FLIT_W     incoming flit
//  data_out         out  FLIT_W     outgoing flit; valid while data_valid=1
//  data_valid       out  1          data_out carries a flit this cycle
//  credit_in        in   1          one-cycle pulse: downstream freed one slot
//  crt_out          out  1          one-cycle pulse to upstream for each flit popped from the FIFO
//  diff_pair_p_out  out  1          packet-start toggle to downstream, P leg
//  diff_pair_n_out  out  1          packet-start toggle to downstream, N leg
//  xbar_req         out  1          request crossbar path for current packet
//  xbar_grant       in   1          crossbar grant, level-sensitive
//  xbar_cfg_vector  out  PORTS      one-hot route; held from REQ until the last flit is sent
//  err_overflow     out  1          sticky: write attempted while FIFO full
//  err_timeout      out  1          sticky watchdog flag
// BEHAVIOUR
//  Reset (rst=0, asynchronous): FIFO empty. credit_cnt=CREDITS. FSM=IDLE. Pair reference=(1,0).
//   All outputs 0, except diff_pair_p_out=1, diff_pair_n_out=0.
//  Start detect: a legal pair has p!=n. A packet start is a legal pair that differs from the pair reference;
//   the reference then updates. An illegal pair (p==n) is ignored and the reference is held.
//  Capture: the flit on input_channel in the start cycle is the header. The next PKT_FLITS-1 cycles are
//   written unconditionally, with no valid gaps. A start seen mid-capture is ignored, but the reference
//   still updates.
//  FIFO full on write: the flit is dropped and err_overflow is set. Upstream obeys credits, so this is an
//   error case only. Simultaneous push and pop on a full FIFO is allowed; the push succeeds.
//  FSM:
//   IDLE -> REQ when the FIFO is non-empty. Register xbar_cfg_vector = 1<<head[DST_LSB+:DST_W] and
//    assert xbar_req.
//   REQ -> SEND when xbar_grant=1. Hold xbar_req and xbar_cfg_vector while waiting.
//   SEND: pop when the FIFO is non-empty and credit_cnt>0. A pop drives data_out and data_valid=1 and
//    pulses crt_out the same cycle. The first pop of a packet toggles both diff_pair_*_out, so they stay
//    complementary.
//   After PKT_FLITS pops -> IDLE. xbar_req, xbar_cfg_vector and data_valid go to 0 the next cycle.
//    If the next header is already at the head, IDLE moves to REQ on the following edge.
//  Latency: the header is captured at edge T0. xbar_req and xbar_cfg_vector are high after T1. With grant
//   already high, SEND is entered at T2 and the header appears on data_out after T3.
//  Credits: the counter is $clog2(CREDITS+1) bits wide.
//   Pop without credit_in: decrement. credit_in without pop: increment, saturating at CREDITS.
//   Both in the same cycle: unchanged. credit_cnt=0 stalls SEND with data_valid=0.
//  xbar_grant dropping in SEND does not abort the packet. The grant is treated as held for the packet.
// CONFIGURATION
//  INOUT_PORT_WDOG_EN defined:
//   A counter runs while in REQ or in a stalled SEND cycle, and clears on any pop or on IDLE.
//   Reaching WDOG_CYC sets err_timeout, which is sticky until reset. Forwarding is unaffected.
//  INOUT_PORT_WDOG_EN undefined: no counter is built and err_timeout is tied to 0.
// TESTING (defaults; header 32'h11000000 means dst=1)
//  Basic packet: after reset, toggle the pair to (0,1) with flits 11000000, 00FF0000, 0000FF00, 000000FF,
//   and xbar_grant=1.
//   -> xbar_cfg_vector=4'b0010. data_out carries the 4 flits in order on 4 consecutive cycles.
//   -> 4 crt_out pulses. The diff_pair_*_out legs toggle once.
//  Credit stall: send 2 packets with no credit_in.
//   -> Exactly 4 flits are forwarded, then data_valid stays 0.
//   -> A single credit_in pulse releases exactly 1 flit.
//  Grant wait: xbar_grant=0 for 10 cycles after the header.
//   -> xbar_req is held with a stable cfg vector and no pops.
//   -> The first flit appears 2 cycles after the grant rises.
//  Illegal pair and overflow: drive the pair (1,1).
//   -> No capture.
//   Then fill the FIFO, keep xbar_grant=0, and start another packet.
//   -> err_overflow=1 and the FIFO contents are unchanged.
//  Reset mid-packet: assert rst in SEND after 2 flits.
//   -> All outputs return to reset values asynchronously and credit_cnt=4.
//   -> The next packet forwards normally.
//  Watchdog (INOUT_PORT_WDOG_EN): hold xbar_grant=0 for 64 cycles.
//   -> err_timeout=1 and stays set after the grant arrives.
//   Without the macro, err_timeout stays 0.

Source files
------------

// File: rtl/inout_port_param.sv
// Purpose: router in/out port. Captures toggle-framed packets into a FIFO, routes the header to a one-hot crossbar config, and forwards flits downstream.
// Latency: header captured at T0; xbar_req/xbar_cfg_vector high after T1; SEND at T2 with grant high; header on data_out after T3.
// Backpressure: credit_cnt==0 stalls SEND; crt_out returns one credit upstream per popped flit; a write into a full FIFO is dropped and flagged.
//
// Ports: clk/rst (async active-low); diff_pair_*_in packet-start toggle; input_channel flit in;
//   data_out/data_valid flit out; credit_in downstream credit return; crt_out upstream credit;
//   diff_pair_*_out start toggle downstream; xbar_req/xbar_grant/xbar_cfg_vector crossbar handshake;
//   err_overflow/err_timeout sticky error flags.
// Optional: define INOUT_PORT_WDOG_EN to build the stall watchdog behind err_timeout.
module inout_port_param #(
  parameter int FLIT_W    = 32,
  parameter int BUF_DEPTH = 4,
  parameter int PORTS     = 4,
  parameter int PKT_FLITS = 4,
  parameter int DST_LSB   = 24,
  parameter int CREDITS   = 4,
  parameter int WDOG_CYC  = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              diff_pair_p_in,
  input  logic              diff_pair_n_in,
  input  logic [FLIT_W-1:0] input_channel,
  output logic [FLIT_W-1:0] data_out,
  output logic              data_valid,
  input  logic              credit_in,
  output logic              crt_out,
  output logic              diff_pair_p_out,
  output logic              diff_pair_n_out,
  output logic              xbar_req,
  input  logic              xbar_grant,
  output logic [PORTS-1:0]  xbar_cfg_vector,
  output logic              err_overflow,
  output logic              err_timeout
);

  localparam int DST_W = $clog2(PORTS);
  localparam int PTR_W = $clog2(BUF_DEPTH);
  localparam int CAP_W = $clog2(PKT_FLITS);
  localparam int POP_W = $clog2(PKT_FLITS + 1);
  localparam int CRD_W = $clog2(CREDITS + 1);

  localparam logic [CAP_W-1:0] CAP_LAST  = CAP_W'(PKT_FLITS - 1);
  localparam logic [POP_W-1:0] POP_ALL   = POP_W'(PKT_FLITS);
  localparam logic [CRD_W-1:0] CRD_MAX   = CRD_W'(CREDITS);
  localparam logic [PTR_W:0]   FIFO_FULL = (PTR_W + 1)'(BUF_DEPTH);
  localparam logic [PORTS-1:0] ONE_HOT_0 = PORTS'(1);

  typedef enum logic [1:0] {IDLE, REQ, SEND} state_t;
  state_t state, state_nxt;

  // ---------------- start detect and capture ----------------
  // The reference pair is always legal, so it is stored as its P leg only.
  logic             ref_p;
  logic             pkt_start;
  logic [CAP_W-1:0] cap_left;
  logic             wr_en;

  assign pkt_start = (diff_pair_p_in ^ diff_pair_n_in) && (diff_pair_p_in != ref_p);
  // Header in the start cycle, then PKT_FLITS-1 gapless body flits.
  assign wr_en     = pkt_start || (cap_left != '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ref_p    <= 1'b1;
      cap_left <= '0;
    end else begin
      // The reference follows every legal change, even one ignored mid-capture.
      if (pkt_start) ref_p <= diff_pair_p_in;
      if (cap_left != '0) cap_left <= cap_left - 1'b1;
      else if (pkt_start) cap_left <= CAP_LAST;
    end
  end

  // ---------------- input FIFO ----------------
  logic [FLIT_W-1:0] mem [BUF_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [PTR_W:0]    fifo_cnt;
  logic              fifo_empty, fifo_full, push, pop;
  logic [FLIT_W-1:0] head;

  assign fifo_empty = (fifo_cnt == '0);
  assign fifo_full  = (fifo_cnt == FIFO_FULL);
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign push       = wr_en && (!fifo_full || pop);
  assign head       = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= input_channel;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fifo_cnt     <= '0;
      err_overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      fifo_cnt <= fifo_cnt + 1'b1;
      else if (pop && !push) fifo_cnt <= fifo_cnt - 1'b1;
      if (wr_en && !push) err_overflow <= 1'b1;
    end
  end

  // ---------------- forwarding FSM ----------------
  logic [POP_W-1:0] pop_cnt;
  logic [CRD_W-1:0] credit_cnt;
  logic [PORTS-1:0] cfg_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // SEND lingers one cycle after the last pop so req/cfg stay up while the
  // last flit is on data_out.
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      IDLE: if (!fifo_empty) state_nxt = REQ;
      REQ:  if (xbar_grant) state_nxt = SEND;
      SEND: begin
        if (pop_cnt == POP_ALL) state_nxt = IDLE;
        else pop = !fifo_empty && (credit_cnt != '0);
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pop_cnt         <= '0;
      cfg_q           <= '0;
      credit_cnt      <= CRD_MAX;
      data_out        <= '0;
      data_valid      <= 1'b0;
      crt_out         <= 1'b0;
      diff_pair_p_out <= 1'b1;
      diff_pair_n_out <= 1'b0;
    end else begin
      data_valid <= pop;
      crt_out    <= pop;
      data_out   <= pop ? head : '0;

      if (state != SEND) pop_cnt <= '0;
      else if (pop)      pop_cnt <= pop_cnt + 1'b1;

      if (state == IDLE && state_nxt == REQ) cfg_q <= ONE_HOT_0 << head[DST_LSB +: DST_W];
      else if (state == SEND && state_nxt == IDLE) cfg_q <= '0;

      // Both legs flip together so the pair stays complementary.
      if (pop && pop_cnt == '0) begin
        diff_pair_p_out <= ~diff_pair_p_out;
        diff_pair_n_out <= ~diff_pair_n_out;
      end

      if (pop && !credit_in) credit_cnt <= credit_cnt - 1'b1;
      else if (credit_in && !pop && credit_cnt != CRD_MAX) credit_cnt <= credit_cnt + 1'b1;
    end
  end

  assign xbar_req        = (state != IDLE);
  assign xbar_cfg_vector = cfg_q;

  // ---------------- stall watchdog ----------------
`ifdef INOUT_PORT_WDOG_EN
  localparam int WD_W = $clog2(WDOG_CYC + 1);
  localparam logic [WD_W-1:0] WD_LIM = WD_W'(WDOG_CYC);

  logic [WD_W-1:0] wd_cnt;
  logic            wd_stall;
  logic            err_to_q;

  assign wd_stall = (state == REQ) || (state == SEND && !pop && pop_cnt != POP_ALL);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wd_cnt   <= '0;
      err_to_q <= 1'b0;
    end else begin
      if (pop || state == IDLE) begin
        wd_cnt <= '0;
      end else if (wd_stall) begin
        if (wd_cnt != WD_LIM) wd_cnt <= wd_cnt + 1'b1;
        // Flag on the edge where the count reaches the limit.
        if (wd_cnt == WD_LIM - 1'b1) err_to_q <= 1'b1;
      end
    end
  end

  assign err_timeout = err_to_q;
`else
  // Always 0; the comparison keeps WDOG_CYC referenced when no watchdog is built.
  assign err_timeout = (WDOG_CYC < 0);
`endif

endmodule
